// File: rtl/loadshift_sched.sv
// loadshift_sched: round-robin scheduler for two byte sources feeding an embedded rotate-left serial shifter.
// Optional even-parity trailer bit when LOADSHIFT_SCHED_PARITY_EN is defined.
module loadshift_sched #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic             C,
   input  logic             R,
   input  logic [WIDTH-1:0] Inp0,
   input  logic             Req0,
   input  logic [WIDTH-1:0] Inp1,
   input  logic             Req1,
   output logic             SO,
   output logic             SV,
   output logic             Ack0,
   output logic             Ack1,
   output logic             Gnt,
   output logic             Busy
);
`ifdef LOADSHIFT_SCHED_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif
   localparam int CW = $clog2(NB);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PAUSE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       gcnt_q, gcnt_d;
   logic             done_q, done_d;
   logic             gnt_d, so_d, sv_d, last;
   assign last = cnt_q == CW'(NB - 1);
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      gnt_d   = Gnt;
      so_d    = 1'b0;
      sv_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (Req0 | Req1) begin
            gnt_d   = (Req0 & Req1) ? ~Gnt : Req1;
            state_d = LOAD;
         end
         LOAD: begin
            sreg_d  = Gnt ? Inp1 : Inp0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
`ifdef LOADSHIFT_SCHED_PARITY_EN
            // rotation preserves the XOR of the word, so parity is taken from the register as-is
            so_d = (cnt_q == CW'(WIDTH)) ? ^sreg_q : sreg_q[WIDTH-1];
`else
            so_d = sreg_q[WIDTH-1];
`endif
            sv_d   = 1'b1;
            sreg_d = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
               done_d  = 1'b1;
               gcnt_d  = '0;
               state_d = (GAP == 0) ? IDLE : PAUSE;
            end
         end
         PAUSE: begin
            gcnt_d = gcnt_q + 1'b1;
            if (gcnt_q == 4'(GAP - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge C) begin
      if (R) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         done_q  <= 1'b0;
         SO      <= 1'b0;
         SV      <= 1'b0;
         Ack0    <= 1'b0;
         Ack1    <= 1'b0;
         Gnt     <= 1'b1;
         Busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         done_q  <= done_d;
         SO      <= so_d;
         SV      <= sv_d;
         Ack0    <= done_q & ~Gnt;
         Ack1    <= done_q & Gnt;
         Gnt     <= gnt_d;
         Busy    <= state_d != IDLE;
      end
   end
endmodule

// File: tb/tb_loadshift_sched.sv
// tb_loadshift_sched: randomized scoreboard bench; a latency-rule model queues expected frames, a monitor checks outputs.
module tb_loadshift_sched;
   localparam int W  = 8;
   localparam int GP = 1;
`ifdef LOADSHIFT_SCHED_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif
   logic C = 1'b0, R = 1'b1, Req0 = 1'b0, Req1 = 1'b0;
   logic [W-1:0] Inp0 = '0, Inp1 = '0;
   logic SO, SV, Ack0, Ack1, Gnt, Busy;
   int vectors = 0, miscompares = 0;
   typedef struct {int who; logic [W-1:0] data; int first; int ack;} fr_t;
   fr_t q[$];
   fr_t cur, nf;
   bit  cur_v = 0, pend = 0, seen = 0;
   int  edge_n = 0, rst_edge = -10, free_at = 0, busy_last = -1, pend_e = -10, pend_g = 0;
   int  k;
   logic mgnt = 1'b1, eb, ea;

   always #5 C = ~C;

   loadshift_sched #(.WIDTH(W), .GAP(GP)) dut (
      .C(C), .R(R), .Inp0(Inp0), .Req0(Req0), .Inp1(Inp1), .Req1(Req1),
      .SO(SO), .SV(SV), .Ack0(Ack0), .Ack1(Ack1), .Gnt(Gnt), .Busy(Busy)
   );

   task automatic chk(input string nm, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %b expected %b", nm, edge_n, act, exp);
      end
   endtask

   function automatic logic fbit(input logic [W-1:0] d, input int i);
      return (i < W) ? d[W-1-i] : ^d;
   endfunction

   task automatic step();
      @(posedge C);
      #1;
   endtask

   task automatic wait_ack(input logic [1:0] m, input string nm);
      bit got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         step();
         got = |({Ack1, Ack0} & m);
      end
      chk(nm, got, 1'b1);
   endtask

   // reference model: grants and frame timing from the latency rules
   initial forever begin
      @(posedge C);
      edge_n++;
      if (R) begin
         seen = 1; rst_edge = edge_n; q.delete(); pend = 0;
         mgnt = 1'b1; free_at = edge_n + 1; busy_last = -1;
      end else begin
         if (pend && edge_n == pend_e + 1) begin
            nf.who = pend_g; nf.data = pend_g ? Inp1 : Inp0;
            nf.first = pend_e + 2; nf.ack = pend_e + NB + 2;
            q.push_back(nf); pend = 0;
         end
         if (edge_n >= free_at && (Req0 || Req1)) begin
            mgnt = (Req0 && Req1) ? !mgnt : Req1;
            pend = 1; pend_e = edge_n; pend_g = int'(mgnt);
            free_at = edge_n + NB + 2 + GP; busy_last = edge_n + NB + GP;
         end
      end
   end

   // monitor: pops the expected frame when its first bit is due
   initial forever begin
      @(negedge C);
      if (seen) begin
         if (rst_edge == edge_n) begin
            cur_v = 0;
            chk("rst_sv", SV, 1'b0); chk("rst_so", SO, 1'b0);
            chk("rst_ack0", Ack0, 1'b0); chk("rst_ack1", Ack1, 1'b0);
            chk("rst_busy", Busy, 1'b0); chk("rst_gnt", Gnt, 1'b1);
         end else begin
            if (!cur_v && q.size() > 0 && q[0].first == edge_n) begin
               cur = q.pop_front(); cur_v = 1;
            end
            k  = edge_n - cur.first;
            eb = cur_v && k >= 0 && k < NB;
            ea = cur_v && edge_n == cur.ack;
            chk("sv", SV, eb);
            chk("so", SO, eb ? fbit(cur.data, k) : 1'b0);
            chk("ack0", Ack0, ea && cur.who == 0);
            chk("ack1", Ack1, ea && cur.who == 1);
            chk("busy", Busy, edge_n <= busy_last);
            chk("gnt", Gnt, mgnt);
            if (ea) cur_v = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      step(); step(); R = 1'b0;
      Inp0 = 8'hA5; Req0 = 1'b1;
      wait_ack(2'b01, "p1_ack0"); Req0 = 1'b0;
      step(); R = 1'b1; step(); R = 1'b0;
      Inp0 = 8'h0F; Inp1 = 8'hF0; Req0 = 1'b1; Req1 = 1'b1;
      wait_ack(2'b01, "p2_ack0"); Req0 = 1'b0;
      wait_ack(2'b10, "p2_ack1"); Req1 = 1'b0;
      Inp0 = W'($urandom); Inp1 = W'($urandom); Req0 = 1'b1; Req1 = 1'b1;
      repeat (4) wait_ack(2'b11, "p3_ack");
      Req0 = 1'b0; Req1 = 1'b0;
      repeat (4) step();
      Inp1 = 8'hFF; Req1 = 1'b1; cnt = 0;
      for (int i = 0; i < 100 && cnt < 3; i++) begin
         @(negedge C);
         if (SV) cnt++;
      end
      chk("p4_started", cnt == 3, 1'b1);
      R = 1'b1;
      step(); R = 1'b0;
      wait_ack(2'b10, "p4_ack1"); Req1 = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (Req0 && Ack0) begin Req0 = 1'($urandom % 2); Inp0 = W'($urandom); end
         else if (!Req0 && $urandom % 4 == 0) begin Req0 = 1'b1; Inp0 = W'($urandom); end
         if (Req1 && Ack1) begin Req1 = 1'($urandom % 2); Inp1 = W'($urandom); end
         else if (!Req1 && $urandom % 4 == 0) begin Req1 = 1'b1; Inp1 = W'($urandom); end
         if (R) R = 1'b0;
         else if ($urandom % 400 == 0) R = 1'b1;
      end
      R = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
      repeat (60) step();
      chk("drain", q.size() == 0 && !cur_v, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
